// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache responder: FSM state encoding,
// address-field constants and the store byte-merge.
package dcache_pkg;

  localparam int unsigned DC_ADDR_W     = 32;
  localparam int unsigned DC_BYTE_OFF_W = 2;
  localparam int unsigned DC_INDEX_BITS = 6;
  localparam int unsigned DC_LINE_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL_REQ,
    ST_REFILL_DATA,
    ST_WRITE_REQ,
    ST_RESPOND
  } state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache: registered read,
// one word write port, and valid bits cleared by the asynchronous reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DC_INDEX_BITS,
  parameter int unsigned WORD_BITS  = 2,
  parameter int unsigned TAG_BITS   = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_en,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [WORD_BITS-1:0]  i_rd_word,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [31:0]           o_rd_data,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [WORD_BITS-1:0]  i_wr_word,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_set_valid,
  input  logic [TAG_BITS-1:0]   i_set_tag
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned WORDS = LINES << WORD_BITS;

  logic [31:0]         r_data [WORDS];
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [LINES-1:0]    r_valid;
  logic                r_rd_valid;
  logic [TAG_BITS-1:0] r_rd_tag;
  logic [31:0]         r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
    if (i_set_valid) r_tag[i_wr_index] <= i_set_tag;
    if (i_rd_en) begin
      r_rd_tag  <= r_tag[i_rd_index];
      r_rd_data <= r_data[{i_rd_index, i_rd_word}];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (i_set_valid) r_valid[i_wr_index] <= 1'b1;
      if (i_rd_en) r_rd_valid <= r_valid[i_rd_index];
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_tag   = r_rd_tag;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data-cache responder.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DC_INDEX_BITS,
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rnw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_we,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);
  localparam int unsigned WADDR_W   = DC_ADDR_W - DC_BYTE_OFF_W;
  localparam int unsigned TAG_BITS  = WADDR_W - INDEX_BITS - WORD_BITS;

  state_t               r_state;
  logic [WADDR_W-1:0]   r_waddr;
  logic [3:0]           r_we;
  logic [31:0]          r_din;
  logic                 r_store;
  logic [WORD_BITS-1:0] r_beat;
  logic [31:0]          r_fill_word;
  logic [31:0]          r_dout;

  logic                  w_accept, w_hit, w_last_beat, w_stall;
  logic                  w_rd_valid;
  logic [TAG_BITS-1:0]   w_rd_tag, w_req_tag;
  logic [31:0]           w_rd_data, w_wr_data, w_dout;
  logic [INDEX_BITS-1:0] w_req_index, w_cpu_index;
  logic [WORD_BITS-1:0]  w_req_word, w_cpu_word, w_wr_word;
  logic                  w_wr_en, w_set_valid;
  logic                  w_unused;

  assign w_unused    = &{1'b0, dcache_addr[DC_BYTE_OFF_W-1:0]};
  assign w_cpu_word  = dcache_addr[DC_BYTE_OFF_W +: WORD_BITS];
  assign w_cpu_index = dcache_addr[DC_BYTE_OFF_W + WORD_BITS +: INDEX_BITS];
  assign w_req_word  = r_waddr[WORD_BITS-1:0];
  assign w_req_index = r_waddr[WORD_BITS +: INDEX_BITS];
  assign w_req_tag   = r_waddr[WADDR_W-1 -: TAG_BITS];
  assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);
  assign w_last_beat = (r_beat == WORD_BITS'(LINE_WORDS - 1));

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_REFILL_REQ, ST_REFILL_DATA, ST_WRITE_REQ: w_stall = 1'b1;
      ST_LOOKUP:                                   w_stall = r_store || !w_hit;
      default:                                     w_stall = 1'b0;
    endcase
  end

  assign stall    = w_stall;
  assign w_accept = (dcache_re || (|dcache_we)) && !w_stall;

  // Load data is combinational in the completing cycle and held afterwards.
  always_comb begin
    w_dout = r_dout;
    if (r_state == ST_LOOKUP && !r_store && w_hit) w_dout = w_rd_data;
    else if (r_state == ST_RESPOND)                w_dout = r_fill_word;
  end
  assign dcache_dout = w_dout;

  always_comb begin
    w_wr_en     = 1'b0;
    w_set_valid = 1'b0;
    w_wr_word   = w_req_word;
    w_wr_data   = byte_merge(w_rd_data, r_din, r_we);
    if (r_state == ST_REFILL_DATA && mem_resp_valid) begin
      w_wr_en     = 1'b1;
      w_wr_word   = r_beat;
      w_wr_data   = mem_resp_data;
      w_set_valid = w_last_beat;
    end else if (r_state == ST_LOOKUP && r_store && w_hit) begin
      w_wr_en = 1'b1;
    end
  end

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .WORD_BITS  (WORD_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_rd_en     (w_accept),
    .i_rd_index  (w_cpu_index),
    .i_rd_word   (w_cpu_word),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_wr_en),
    .i_wr_index  (w_req_index),
    .i_wr_word   (w_wr_word),
    .i_wr_data   (w_wr_data),
    .i_set_valid (w_set_valid),
    .i_set_tag   (w_req_tag)
  );

  assign mem_req_valid = (r_state == ST_REFILL_REQ) || (r_state == ST_WRITE_REQ);
  assign mem_req_rnw   = (r_state == ST_REFILL_REQ);
  assign mem_req_addr  = mem_req_rnw
                       ? {r_waddr[WADDR_W-1:WORD_BITS], {(WORD_BITS + DC_BYTE_OFF_W){1'b0}}}
                       : {r_waddr, {DC_BYTE_OFF_W{1'b0}}};
  assign mem_req_data  = r_din;
  assign mem_req_we    = r_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_waddr     <= '0;
      r_we        <= '0;
      r_din       <= '0;
      r_store     <= 1'b0;
      r_beat      <= '0;
      r_fill_word <= '0;
      r_dout      <= '0;
    end else begin
      r_dout <= w_dout;
      if (w_accept) begin
        r_waddr <= dcache_addr[DC_ADDR_W-1:DC_BYTE_OFF_W];
        r_we    <= dcache_we;
        r_din   <= dcache_din;
        r_store <= |dcache_we;
      end
      case (r_state)
        ST_IDLE, ST_RESPOND: r_state <= w_accept ? ST_LOOKUP : ST_IDLE;
        ST_LOOKUP: begin
          if (r_store)     r_state <= ST_WRITE_REQ;
          else if (!w_hit) r_state <= ST_REFILL_REQ;
          else             r_state <= w_accept ? ST_LOOKUP : ST_IDLE;
        end
        ST_REFILL_REQ: begin
          if (mem_req_ready) begin
            r_state <= ST_REFILL_DATA;
            r_beat  <= '0;
          end
        end
        ST_REFILL_DATA: begin
          if (mem_resp_valid) begin
            r_beat <= r_beat + WORD_BITS'(1);
            if (r_beat == w_req_word) r_fill_word <= mem_resp_data;
            if (w_last_beat) r_state <= ST_RESPOND;
          end
        end
        ST_WRITE_REQ: if (mem_req_ready) r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == ST_LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: load results and memory requests are
// queued at issue time and compared by independent monitor processes.
module tb_dcache_responder;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dcache_addr = '0;
  logic        dcache_re = 1'b0;
  logic [3:0]  dcache_we = '0;
  logic [31:0] dcache_din = '0;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_rnw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_we;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_pass = 0;
  int n_rd_reqs = 0;
  int beats_sent = 0;
  int ready_delay = 0;
  bit pend_load = 0;

  req_t        exp_req[$];
  logic [31:0] exp_load[$];
  logic [31:0] bmem [int unsigned];

  dcache_responder #(.INDEX_BITS(6), .LINE_WORDS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rnw    (mem_req_rnw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_we     (mem_req_we),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'hD000_0000 | a;
  endfunction

  // CPU-side monitor: a load completes at the first stall-free cycle after acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) pend_load = 0;
      else begin
        if (pend_load && !stall) begin
          pend_load = 0;
          if (exp_load.size() == 0) chk("unexpected_load", dcache_dout, 32'hFFFF_FFFF);
          else chk("load_dout", dcache_dout, exp_load.pop_front());
        end
        if (!stall && (dcache_re || dcache_we != 4'b0)) pend_load = (dcache_we == 4'b0);
      end
    end
  end

  // Backing memory: accepts requests, checks them, returns refill beats.
  initial begin
    req_t got, e;
    logic [31:0] old;
    forever begin
      @(negedge clk);
      if (mem_req_valid && rst) begin
        repeat (ready_delay) @(negedge clk);
        ready_delay = 0;
        got.rnw = mem_req_rnw; got.addr = mem_req_addr;
        got.data = mem_req_data; got.we = mem_req_we;
        if (rst) begin
          mem_req_ready = 1'b1;
          @(posedge clk);
          #1 mem_req_ready = 1'b0;
          if (exp_req.size() == 0) chk("unexpected_req", got.addr, 32'hFFFF_FFFF);
          else begin
            e = exp_req.pop_front();
            chk("req_rnw", {31'b0, got.rnw}, {31'b0, e.rnw});
            chk("req_addr", got.addr, e.addr);
            if (!e.rnw) begin
              chk("req_data", got.data, e.data);
              chk("req_we", {28'b0, got.we}, {28'b0, e.we});
            end
          end
          if (got.rnw) begin
            n_rd_reqs++;
            for (int i = 0; i < 4; i++) begin
              @(negedge clk);
              if (!rst) break;
              mem_resp_valid = 1'b1;
              mem_resp_data  = bmem_rd(got.addr + 32'(4 * i));
              @(negedge clk);
              mem_resp_valid = 1'b0;
              if (!rst) break;
              beats_sent++;
            end
            mem_resp_valid = 1'b0;
          end else begin
            old = bmem_rd(got.addr);
            for (int b = 0; b < 4; b++)
              if (got.we[b]) old[8*b +: 8] = got.data[8*b +: 8];
            bmem[got.addr] = old;
          end
        end
      end
    end
  end

  task automatic push_req(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    req_t r;
    r.rnw = rnw; r.addr = a; r.data = d; r.we = we;
    exp_req.push_back(r);
  endtask

  // Called at posedge+#1; returns at posedge+#1 of the LOOKUP cycle.
  task automatic issue(input logic re, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    bit acc = 0;
    dcache_re = re; dcache_we = we; dcache_addr = a; dcache_din = d;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (!stall) acc = 1;
    end
    chk("accept_in_time", {31'b0, acc}, 32'd1);
    @(posedge clk);
    #1 dcache_re = 1'b0; dcache_we = 4'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!stall && !pend_load && exp_load.size() == 0 && exp_req.size() == 0) done = 1;
    end
    chk("drain_in_time", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;
    for (int i = 0; i < 4; i++) bmem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_dout", dcache_dout, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, then an immediate reload that must hit with 1-cycle latency.
    push_req(1'b1, 32'h1000, '0, '0);
    exp_load.push_back(32'h0000_00A1);
    issue(1'b1, 4'b0, 32'h1004, '0);
    chk("stall_lookup_miss", {31'b0, stall}, 32'd1);
    exp_load.push_back(32'h0000_00A2);
    issue(1'b1, 4'b0, 32'h1008, '0);
    @(negedge clk);
    chk("stall_reload_hit", {31'b0, stall}, 32'd0);
    wait_done();
    chk("rd_reqs_after_cold", n_rd_reqs, 32'd1);

    // Store hits merge into the line and write through.
    push_req(1'b0, 32'h1004, 32'h0000_BEEF, 4'b0011);
    issue(1'b0, 4'b0011, 32'h1004, 32'h0000_BEEF);
    push_req(1'b0, 32'h1008, 32'h1234_0000, 4'b1100);
    issue(1'b1, 4'b1100, 32'h1008, 32'h1234_0000);
    exp_load.push_back(32'h0000_BEEF);
    issue(1'b1, 4'b0, 32'h1004, '0);
    exp_load.push_back(32'h1234_00A2);
    issue(1'b1, 4'b0, 32'h1008, '0);
    exp_load.push_back(32'h0000_00A3);
    issue(1'b1, 4'b0, 32'h100C, '0);
    wait_done();
    chk("rd_reqs_after_store_hit", n_rd_reqs, 32'd1);

    // Store miss does not allocate: the next load there refills.
    push_req(1'b0, 32'h2000, 32'h55AA_55AA, 4'b1111);
    issue(1'b0, 4'b1111, 32'h2000, 32'h55AA_55AA);
    push_req(1'b1, 32'h2000, '0, '0);
    exp_load.push_back(32'h55AA_55AA);
    issue(1'b1, 4'b0, 32'h2000, '0);
    exp_load.push_back(32'hD000_2004);
    issue(1'b1, 4'b0, 32'h2004, '0);
    wait_done();
    chk("rd_reqs_after_store_miss", n_rd_reqs, 32'd2);

    // Backpressure: request fields and stall hold while ready is low.
    ready_delay = 5;
    push_req(1'b1, 32'h3000, '0, '0);
    exp_load.push_back(32'hD000_3008);
    issue(1'b1, 4'b0, 32'h3008, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid) seen = 1;
    end
    chk("bp_req_seen", {31'b0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("bp_addr", mem_req_addr, 32'h3000);
      chk("bp_rnw", {31'b0, mem_req_rnw}, 32'd1);
      chk("bp_stall", {31'b0, stall}, 32'd1);
      if (i < 4) @(negedge clk);
    end
    wait_done();

    // Reset after two refill beats: the line must stay invalid.
    base = beats_sent;
    push_req(1'b1, 32'h4000, '0, '0);
    exp_load.push_back(32'hD000_4004);
    issue(1'b1, 4'b0, 32'h4004, '0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (beats_sent >= base + 2) seen = 1;
    end
    chk("two_beats_seen", {31'b0, seen}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("midrst_dout", dcache_dout, 32'd0);
    exp_load.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_req(1'b1, 32'h4000, '0, '0);
    exp_load.push_back(32'hD000_4004);
    issue(1'b1, 4'b0, 32'h4004, '0);
    wait_done();
    chk("rd_reqs_final", n_rd_reqs, 32'd5);
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("load_queue_empty", exp_load.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
